// File: rtl/fir_sample_feeder_if.sv
// Host/filter signal bundle for fir_sample_feeder. The feeder connects through
// the slave modport; whatever drives the host writes and modwait uses master.
interface fir_sample_feeder_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_COEFF = 4
);
  localparam int SW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [15:0]   wr_data;
  logic          coeff_wr_en;
  logic [SW-1:0] coeff_sel;
  logic [15:0]   coeff_data;
  logic          coeff_start;
  logic          modwait;
  logic          data_ready;
  logic [15:0]   sample_data;
  logic          load_coeff;
  logic [15:0]   fir_coefficient;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          coeff_busy;
  logic          overrun;
  logic          timeout;

  modport slave (
    input  wr_en, wr_data, coeff_wr_en, coeff_sel, coeff_data, coeff_start, modwait,
    output data_ready, sample_data, load_coeff, fir_coefficient,
           full, empty, count, coeff_busy, overrun, timeout
  );

  modport master (
    output wr_en, wr_data, coeff_wr_en, coeff_sel, coeff_data, coeff_start, modwait,
    input  data_ready, sample_data, load_coeff, fir_coefficient,
           full, empty, count, coeff_busy, overrun, timeout
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Sample FIFO plus coefficient shadow bank, sequenced into the FIR filter on modwait.
// Define FEEDER_TIMEOUT_EN to add the issue-state watchdog (TIMEOUT_CYCLES).
module fir_sample_feeder #(
  parameter int DEPTH          = 8,
  parameter int NUM_COEFF      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                n_reset,
  fir_sample_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] C_ISSUE = 3'd3;
  localparam logic [2:0] C_WAIT  = 3'd4;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] LAST_IDX   = SW'(NUM_COEFF - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          avail_q, avail_d;
  logic          pending_q, pending_d;
  logic          overrun_q;

  logic          full_w;
  logic          push;
  logic          pop;
  logic          load_head;
  logic          clr_pending;
  logic          bank_we;
  logic          expire;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   head_q;
  logic [NUM_COEFF-1:0][15:0] bank_w;

  // ---------------------------------------------------------------- FIFO
  assign full_w = (count_q == FULL_COUNT);
  assign push   = bus.wr_en & ~full_w;

  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // avail_q is a one-cycle-late view of "FIFO not empty"; it is forced low
  // after a pop so IDLE never trusts an occupancy that the pop just consumed.
  assign avail_d  = (count_q != '0) & ~pop;

  // Storage and head capture carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
    if (load_head) begin
      head_q <= mem_q[rd_ptr_q];
    end
  end

  // --------------------------------------------------------- shadow bank
  assign bank_we = bus.coeff_wr_en & ~pending_q;

  for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_bank
    logic [15:0] val_q;

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        val_q <= '0;
      end else if (bank_we && (bus.coeff_sel == SW'(gi))) begin
        val_q <= bus.coeff_data;
      end
    end

    assign bank_w[gi] = val_q;
  end

  // ------------------------------------------------------------ sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pop         = 1'b0;
    load_head   = 1'b0;
    clr_pending = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = C_ISSUE;
          idx_d   = '0;
        end else if (avail_q) begin
          state_d   = S_ISSUE;
          load_head = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.modwait) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.modwait) begin
          state_d = IDLE;
        end
      end
      C_ISSUE: begin
        if (bus.modwait) begin
          state_d = C_WAIT;
        end
      end
      C_WAIT: begin
        if (!bus.modwait) begin
          idx_d = idx_q + SW'(1);
          if (idx_q == LAST_IDX) begin
            clr_pending = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = C_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A watchdog expiry abandons the offer: samples are dropped, sequences aborted.
    if (expire) begin
      state_d     = IDLE;
      load_head   = 1'b0;
      pop         = (state_q == S_ISSUE);
      clr_pending = (state_q == C_ISSUE);
    end
  end

  assign pending_d = clr_pending ? 1'b0 : (pending_q | bus.coeff_start);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      avail_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      avail_q   <= avail_d;
      pending_q <= pending_d;
      overrun_q <= bus.wr_en & full_w;
    end
  end

  // ------------------------------------------------------------- watchdog
`ifdef FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q;
  logic          in_issue;

  assign in_issue = (state_q == S_ISSUE) || (state_q == C_ISSUE);
  assign expire   = in_issue && !bus.modwait && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  // The count restarts from zero on every state entry.
  always_comb begin
    wd_d = '0;
    if (in_issue && (state_d == state_q)) begin
      wd_d = wd_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= expire;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
  assign bus.timeout        = 1'b0;
`endif

  // -------------------------------------------------------------- outputs
  assign bus.data_ready      = (state_q == S_ISSUE);
  assign bus.load_coeff      = (state_q == C_ISSUE);
  assign bus.sample_data     = (state_q == S_ISSUE) ? head_q : 16'h0000;
  assign bus.fir_coefficient = (state_q == C_ISSUE) ? bank_w[idx_q] : 16'h0000;
  assign bus.full            = full_w;
  assign bus.empty           = (count_q == '0);
  assign bus.count           = count_q;
  assign bus.coeff_busy      = pending_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder; a small filter model answers offers on modwait.
// The watchdog scenario follows FEEDER_TIMEOUT_EN, as the design does.
module tb_fir_sample_feeder;
  localparam int DEPTH          = 8;
  localparam int NUM_COEFF      = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic clk     = 1'b0;
  logic n_reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fir_sample_feeder_if #(.DEPTH(DEPTH), .NUM_COEFF(NUM_COEFF)) bus ();

  fir_sample_feeder #(
    .DEPTH(DEPTH),
    .NUM_COEFF(NUM_COEFF),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_offer(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.data_ready || bus.load_coeff) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Filter model: accept the current offer and hold modwait for 'hold' cycles.
  // item = {is_coeff, value}.
  task automatic serve(input int hold, output bit got, output logic [16:0] item);
    item = '0;
    wait_offer(got);
    if (!got) return;
    check("mutual_excl", {31'd0, bus.data_ready & bus.load_coeff}, 32'd0);
    item = {bus.load_coeff, bus.load_coeff ? bus.fir_coefficient : bus.sample_data};
    $display("offer %s value=%h", item[16] ? "coeff " : "sample", item[15:0]);
    bus.modwait = 1'b1;
    step();
    check("offer_drops", {31'd0, bus.data_ready | bus.load_coeff}, 32'd0);
    for (int i = 1; i < hold; i++) step();
    bus.modwait = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit          got;
    logic [16:0] item;
    int          ov_sum;
    int          extra;
    logic [16:0] exp4 [6];

    bus.wr_en       = 1'b0;
    bus.wr_data     = '0;
    bus.coeff_wr_en = 1'b0;
    bus.coeff_sel   = '0;
    bus.coeff_data  = '0;
    bus.coeff_start = 1'b0;
    bus.modwait     = 1'b0;

    // Reset values
    #3 n_reset = 1'b0;
    #1;
    check("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
    check("rst_load_coeff", {31'd0, bus.load_coeff}, 32'd0);
    check("rst_sample", {16'd0, bus.sample_data}, 32'd0);
    check("rst_coeff", {16'd0, bus.fir_coefficient}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_count", {28'd0, bus.count}, 32'd0);
    check("rst_busy", {31'd0, bus.coeff_busy}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    step();
    step();
    n_reset = 1'b1;
    step();

    // 1: single sample latency and pop timing
    bus.wr_data = 16'h1234;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    check("t1_count", {28'd0, bus.count}, 32'd1);
    check("t1_dr_edgeN", {31'd0, bus.data_ready}, 32'd0);
    step();
    check("t1_dr_edgeN1", {31'd0, bus.data_ready}, 32'd0);
    step();
    check("t1_dr_edgeN2", {31'd0, bus.data_ready}, 32'd1);
    check("t1_sample", {16'd0, bus.sample_data}, 32'h1234);
    bus.modwait = 1'b1;
    step();
    check("t1_dr_after_pop", {31'd0, bus.data_ready}, 32'd0);
    check("t1_empty", {31'd0, bus.empty}, 32'd1);
    step();
    step();
    bus.modwait = 1'b0;
    step();
    step();
    check("t1_no_reoffer", {31'd0, bus.data_ready}, 32'd0);

    // 2: overflow while the filter stays busy
    bus.wr_data = 16'h9999;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    wait_offer(got);
    check("t2_primer_offer", {31'd0, got}, 32'd1);
    check("t2_primer_value", {16'd0, bus.sample_data}, 32'h9999);
    bus.modwait = 1'b1;
    step();
    ov_sum = 0;
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = 16'hA000 + 16'(i);
      bus.wr_en   = 1'b1;
      step();
      ov_sum += int'(bus.overrun);
      $display("push %h count=%0d full=%0d overrun=%0d", bus.wr_data, bus.count, bus.full, bus.overrun);
    end
    bus.wr_en = 1'b0;
    check("t2_count", {28'd0, bus.count}, 32'd8);
    check("t2_full", {31'd0, bus.full}, 32'd1);
    check("t2_overrun_now", {31'd0, bus.overrun}, 32'd1);
    step();
    ov_sum += int'(bus.overrun);
    check("t2_overrun_pulses", ov_sum, 32'd1);
    bus.modwait = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve(1, got, item);
      check("t2_drain_offer", {31'd0, got}, 32'd1);
      check("t2_drain_value", {15'd0, item}, {15'd0, 1'b0, 16'hA000 + 16'(i)});
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_ready || bus.load_coeff) extra++;
    end
    check("t2_ninth_absent", extra, 32'd0);
    check("t2_empty", {31'd0, bus.empty}, 32'd1);

    // 3: coefficient load sequence
    for (int i = 0; i < 4; i++) begin
      bus.coeff_wr_en = 1'b1;
      bus.coeff_sel   = 2'(i);
      bus.coeff_data  = 16'(i + 1);
      step();
    end
    bus.coeff_wr_en = 1'b0;
    bus.coeff_start = 1'b1;
    step();
    bus.coeff_start = 1'b0;
    check("t3_busy_set", {31'd0, bus.coeff_busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      serve(2, got, item);
      check("t3_offer", {31'd0, got}, 32'd1);
      check("t3_value", {15'd0, item}, {15'd0, 1'b1, 16'(i + 1)});
    end
    check("t3_busy_before_last_wait", {31'd0, bus.coeff_busy}, 32'd1);
    step();
    check("t3_busy_clear", {31'd0, bus.coeff_busy}, 32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_ready || bus.load_coeff) extra++;
    end
    check("t3_no_fifth", extra, 32'd0);

    // 4: coeff_start while a sample sits in S_WAIT with two more queued
    for (int i = 1; i <= 3; i++) begin
      bus.wr_data = 16'hB000 + 16'(i);
      bus.wr_en   = 1'b1;
      step();
    end
    bus.wr_en = 1'b0;
    wait_offer(got);
    check("t4_first_offer", {31'd0, got}, 32'd1);
    check("t4_first_value", {16'd0, bus.sample_data}, 32'hB001);
    bus.modwait = 1'b1;
    step();
    bus.coeff_start = 1'b1;
    step();
    bus.coeff_start = 1'b0;
    check("t4_busy", {31'd0, bus.coeff_busy}, 32'd1);
    bus.coeff_wr_en = 1'b1;
    bus.coeff_sel   = 2'd0;
    bus.coeff_data  = 16'hDEAD;
    step();
    bus.coeff_wr_en = 1'b0;
    check("t4_held_in_wait", {31'd0, bus.data_ready | bus.load_coeff}, 32'd0);
    bus.modwait = 1'b0;
    exp4[0] = {1'b1, 16'h0001};
    exp4[1] = {1'b1, 16'h0002};
    exp4[2] = {1'b1, 16'h0003};
    exp4[3] = {1'b1, 16'h0004};
    exp4[4] = {1'b0, 16'hB002};
    exp4[5] = {1'b0, 16'hB003};
    for (int i = 0; i < 6; i++) begin
      serve(1, got, item);
      check("t4_offer", {31'd0, got}, 32'd1);
      check("t4_order", {15'd0, item}, {15'd0, exp4[i]});
    end

    // 5: asynchronous reset during C_ISSUE
    bus.coeff_start = 1'b1;
    bus.wr_data     = 16'hC001;
    bus.wr_en       = 1'b1;
    step();
    bus.coeff_start = 1'b0;
    bus.wr_en       = 1'b0;
    wait_offer(got);
    check("t5_in_c_issue", {31'd0, bus.load_coeff}, 32'd1);
    #2 n_reset = 1'b0;
    #1;
    check("t5_load_coeff", {31'd0, bus.load_coeff}, 32'd0);
    check("t5_data_ready", {31'd0, bus.data_ready}, 32'd0);
    check("t5_busy", {31'd0, bus.coeff_busy}, 32'd0);
    check("t5_count", {28'd0, bus.count}, 32'd0);
    check("t5_empty", {31'd0, bus.empty}, 32'd1);
    step();
    n_reset = 1'b1;
    step();
    bus.coeff_start = 1'b1;
    step();
    bus.coeff_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(1, got, item);
      check("t5_bank_offer", {31'd0, got}, 32'd1);
      check("t5_bank_zero", {15'd0, item}, {15'd0, 1'b1, 16'h0000});
    end
    step();
    check("t5_busy_after", {31'd0, bus.coeff_busy}, 32'd0);
    check("t5_fifo_still_empty", {31'd0, bus.empty}, 32'd1);

    // 6: filter never answers a sample offer
    bus.wr_data = 16'hD001;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    wait_offer(got);
    check("t6_offer", {31'd0, got}, 32'd1);
`ifdef FEEDER_TIMEOUT_EN
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.data_ready) break;
      extra++;
      step();
    end
    check("t6_issue_cycles", extra, TIMEOUT_CYCLES);
    check("t6_timeout_pulse", {31'd0, bus.timeout}, 32'd1);
    check("t6_dr_low", {31'd0, bus.data_ready}, 32'd0);
    step();
    check("t6_timeout_one_cycle", {31'd0, bus.timeout}, 32'd0);
    check("t6_discarded", {31'd0, bus.empty}, 32'd1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.data_ready) extra++;
    end
    check("t6_no_reoffer", extra, 32'd0);
`else
    extra = 0;
    for (int i = 0; i < TIMEOUT_CYCLES + 6; i++) begin
      step();
      if (bus.timeout) extra++;
      if (!bus.data_ready) extra++;
    end
    check("t6_waits_forever", extra, 32'd0);
    serve(1, got, item);
    check("t6_late_accept", {15'd0, item}, {15'd0, 1'b0, 16'hD001});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
